// File: rtl/row_feeder.sv
// rtl/row_feeder.sv - fetches image rows pixel by pixel and writes them into three line buffers
module row_feeder #(
  parameter int PIX_W    = 8,
  parameter int ROW_PIX  = 100,
  parameter int NUM_ROWS = 100,
  parameter int ADDR_W   = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     img_rd_en,
  output logic [ADDR_W-1:0]        img_rd_addr,
  input  logic [PIX_W-1:0]         img_rd_data,
  output logic [ROW_PIX*PIX_W-1:0] ram1,
  output logic [ROW_PIX*PIX_W-1:0] ram2,
  output logic [ROW_PIX*PIX_W-1:0] ram3,
  output logic [2:0]               wr_en,
  input  logic                     conv_valid,
  input  logic [1:0]               conv_k,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int ROW_W = ROW_PIX * PIX_W;
  // Assembly holds all pixels but the last; the last one is merged straight from the read bus.
  localparam int ASM_W = ROW_W - PIX_W;
  localparam int COL_W = $clog2(ROW_PIX + 1);
  localparam int RC_W  = $clog2(NUM_ROWS + 1);

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(ROW_PIX);
  localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(NUM_ROWS);
  localparam logic [RC_W-1:0]   RC_FILL  = RC_W'(3);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_PIX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [COL_W-1:0]  r_col;        // fetch cycle index within the current row
  logic [RC_W-1:0]   r_row_cnt;
  logic [1:0]        r_target;     // line buffer receiving the row being fetched
  logic [ADDR_W-1:0] r_row_base;   // address of pixel 0 of the current row
  logic [ASM_W-1:0]  r_asm;
  logic              r_pend;
  logic [1:0]        r_pend_k;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ROW_W-1:0]  r_ram1;
  logic [ROW_W-1:0]  r_ram2;
  logic [ROW_W-1:0]  r_ram3;
  logic [2:0]        r_wr_en;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [COL_W-1:0]  w_next_col;
  logic [ADDR_W-1:0] w_next_addr;
  logic [RC_W-1:0]   w_rc_nx;
  logic [ROW_W-1:0]  w_row_full;
  logic              w_conv_ok;
  logic              w_conv_bad;

  assign w_next_col  = r_col + COL_W'(1);
  assign w_next_addr = r_row_base + ADDR_W'(w_next_col);
  assign w_rc_nx     = r_row_cnt + RC_W'(1);
  // Pixel 0 sits in the lowest slot after the shifts, so the last pixel lands on top.
  assign w_row_full  = {img_rd_data, r_asm};
  // A free-buffer request is acceptable only with a legal index and no request already queued.
  assign w_conv_ok   = conv_valid && (conv_k != 2'd3) && !r_pend;
  assign w_conv_bad  = conv_valid && ((conv_k == 2'd3) || r_pend);

  assign img_rd_en   = r_rd_en;
  assign img_rd_addr = r_rd_addr;
  assign ram1        = r_ram1;
  assign ram2        = r_ram2;
  assign ram3        = r_ram3;
  assign wr_en       = r_wr_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

  // Main FSM: row sequencing, pixel assembly, line-buffer writes and free-buffer request tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row_cnt  <= '0;
      r_target   <= 2'd0;
      r_row_base <= '0;
      r_asm      <= '0;
      r_pend     <= 1'b0;
      r_pend_k   <= 2'd0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_ram1     <= '0;
      r_ram2     <= '0;
      r_ram3     <= '0;
      r_wr_en    <= 3'b000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 3'b000;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_row_cnt  <= '0;
            r_target   <= 2'd0;
            r_row_base <= '0;
            r_pend     <= 1'b0;
            r_col      <= '0;
            r_rd_en    <= 1'b1;
            r_rd_addr  <= '0;
          end
        end

        S_FETCH: begin
          if (w_conv_ok) begin
            r_pend   <= 1'b1;
            r_pend_k <= conv_k;
          end
          if (w_conv_bad) begin
            r_err <= 1'b1;
          end
          if (r_col == LAST_COL) begin
            // Final fetch cycle: the last pixel goes directly into the selected buffer.
            r_state <= S_WRITE;
            case (r_target)
              2'd0: begin
                r_ram1  <= w_row_full;
                r_wr_en <= 3'b001;
              end
              2'd1: begin
                r_ram2  <= w_row_full;
                r_wr_en <= 3'b010;
              end
              default: begin
                r_ram3  <= w_row_full;
                r_wr_en <= 3'b100;
              end
            endcase
          end else begin
            // Data for column r_col-1 is on the bus this cycle.
            if (r_col != '0) begin
              r_asm <= {img_rd_data, r_asm[ASM_W-1:PIX_W]};
            end
            r_col <= w_next_col;
            if (w_next_col == LAST_COL) begin
              r_rd_en <= 1'b0;
            end else begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_next_addr;
            end
          end
        end

        S_WRITE: begin
          if (w_conv_ok) begin
            r_pend   <= 1'b1;
            r_pend_k <= conv_k;
          end
          if (w_conv_bad) begin
            r_err <= 1'b1;
          end
          r_row_cnt  <= w_rc_nx;
          r_row_base <= r_row_base + ROW_STEP;
          if (w_rc_nx == RC_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_rc_nx < RC_FILL) begin
            // Initial fill: buffers are loaded in order without consumer handshakes.
            r_state   <= S_FETCH;
            r_target  <= r_target + 2'd1;
            r_col     <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_row_base + ROW_STEP;
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (r_pend) begin
            r_pend    <= 1'b0;
            r_target  <= r_pend_k;
            r_state   <= S_FETCH;
            r_col     <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_row_base;
            if (conv_valid) begin
              r_err <= 1'b1;
            end
          end else if (w_conv_ok) begin
            r_target  <= conv_k;
            r_state   <= S_FETCH;
            r_col     <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_row_base;
          end else if (w_conv_bad) begin
            r_err <= 1'b1;
          end
        end

        S_DONE: begin
          r_pend  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_feeder.sv
// tb/tb_row_feeder.sv - directed self-checking bench for row_feeder
module tb_row_feeder;

  localparam int RW = 800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          conv_valid = 1'b0;
  logic [1:0]    conv_k = 2'd0;
  logic [7:0]    img_rd_data = 8'd0;
  logic          img_rd_en;
  logic [13:0]   img_rd_addr;
  logic [RW-1:0] ram1, ram2, ram3;
  logic [2:0]    wr_en;
  logic          busy, done, err;

  logic          rst_b = 1'b1;
  logic          start_b = 1'b0;
  logic          conv_valid_b = 1'b0;
  logic [1:0]    conv_k_b = 2'd0;
  logic [7:0]    img_rd_data_b = 8'd0;
  logic          img_rd_en_b;
  logic [13:0]   img_rd_addr_b;
  logic [RW-1:0] ram1_b, ram2_b, ram3_b;
  logic [2:0]    wr_en_b;
  logic          busy_b, done_b, err_b;

  row_feeder dut (
    .clk(clk), .rst(rst), .start(start),
    .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
    .ram1(ram1), .ram2(ram2), .ram3(ram3), .wr_en(wr_en),
    .conv_valid(conv_valid), .conv_k(conv_k),
    .busy(busy), .done(done), .err(err)
  );

  row_feeder #(.NUM_ROWS(3)) dut3 (
    .clk(clk), .rst(rst_b), .start(start_b),
    .img_rd_en(img_rd_en_b), .img_rd_addr(img_rd_addr_b), .img_rd_data(img_rd_data_b),
    .ram1(ram1_b), .ram2(ram2_b), .ram3(ram3_b), .wr_en(wr_en_b),
    .conv_valid(conv_valid_b), .conv_k(conv_k_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  // image memory: memory[a] = a[7:0], one cycle read latency
  always @(posedge clk) if (img_rd_en) img_rd_data <= img_rd_addr[7:0];
  always @(posedge clk) if (img_rd_en_b) img_rd_data_b <= img_rd_addr_b[7:0];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_mark = 0;

  function automatic logic [RW-1:0] row_val(input int base);
    logic [RW-1:0] r;
    for (int c = 0; c < 100; c++) r[c*8 +: 8] = 8'(base + c);
    return r;
  endfunction

  task tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_wr(input int limit, output bit ok);
    int n;
    n = 0;
    while (wr_en === 3'b000 && n < limit) begin tick(); n++; end
    ok = (wr_en !== 3'b000);
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_b = 1'b1;
    tick(); tick();
    total++; if (wr_en !== 3'b000 || img_rd_en !== 1'b0 || img_rd_addr !== 14'd0) begin bad++; $display("FAIL rst_io: wr_en=%b rd_en=%b addr=%0d want 000 0 0", wr_en, img_rd_en, img_rd_addr); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_flags: busy=%b done=%b err=%b want 0 0 0", busy, done, err); end
    total++; if (busy_b !== 1'b0 || wr_en_b !== 3'b000) begin bad++; $display("FAIL rst_b: busy=%b wr_en=%b want 0 000", busy_b, wr_en_b); end
    rst = 1'b0; rst_b = 1'b0;
    tick();
  endtask

  task automatic test_first_fill(input string tag);
    bit ok;
    int n_wr, n_rd;
    start = 1'b1; t_mark = cyc; tick(); start = 1'b0;
    total++; if (busy !== 1'b1 || img_rd_en !== 1'b1 || img_rd_addr !== 14'd0 || err !== 1'b0) begin bad++; $display("FAIL %s_fetch0: busy=%b rd_en=%b addr=%0d err=%b want 1 1 0 0", tag, busy, img_rd_en, img_rd_addr, err); end
    wait_wr(200, ok);
    total++; if (!ok || cyc - t_mark != 102 || wr_en !== 3'b001) begin bad++; $display("FAIL %s_row0: cycle=%0d wr_en=%b want 102 001", tag, cyc - t_mark, wr_en); end
    total++; if (ram1 !== row_val(0)) begin bad++; $display("FAIL %s_ram1: got %h want %h", tag, ram1, row_val(0)); end
    tick();
    total++; if (wr_en !== 3'b000) begin bad++; $display("FAIL %s_pulse: wr_en=%b want 000", tag, wr_en); end
    wait_wr(200, ok);
    total++; if (!ok || cyc - t_mark != 204 || wr_en !== 3'b010) begin bad++; $display("FAIL %s_row1: cycle=%0d wr_en=%b want 204 010", tag, cyc - t_mark, wr_en); end
    total++; if (ram2 !== row_val(100) || ram1 !== row_val(0)) begin bad++; $display("FAIL %s_ram2: got %h want %h", tag, ram2, row_val(100)); end
    tick();
    wait_wr(200, ok);
    total++; if (!ok || cyc - t_mark != 306 || wr_en !== 3'b100) begin bad++; $display("FAIL %s_row2: cycle=%0d wr_en=%b want 306 100", tag, cyc - t_mark, wr_en); end
    total++; if (ram3 !== row_val(200)) begin bad++; $display("FAIL %s_ram3: got %h want %h", tag, ram3, row_val(200)); end
    n_wr = 0; n_rd = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (wr_en !== 3'b000) n_wr++;
      if (img_rd_en !== 1'b0) n_rd++;
    end
    total++; if (n_wr != 0 || n_rd != 0 || busy !== 1'b1) begin bad++; $display("FAIL %s_wait: writes=%0d reads=%0d busy=%b want 0 0 1", tag, n_wr, n_rd, busy); end
  endtask

  task automatic test_conv_wait();
    conv_valid = 1'b1; conv_k = 2'd1; t_mark = cyc; tick(); conv_valid = 1'b0;
    total++; if (img_rd_en !== 1'b1 || img_rd_addr !== 14'd300 || wr_en !== 3'b000 || err !== 1'b0) begin bad++; $display("FAIL cw_fetch: rd_en=%b addr=%0d wr_en=%b err=%b want 1 300 000 0", img_rd_en, img_rd_addr, wr_en, err); end
  endtask

  task automatic test_pending();
    bit ok;
    int n_wr, n_rd;
    repeat (9) tick();
    conv_valid = 1'b1; conv_k = 2'd2; tick(); conv_valid = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL pend_first_err: err=%b want 0", err); end
    repeat (8) tick();
    conv_valid = 1'b1; conv_k = 2'd0; tick(); conv_valid = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL pend_second_err: err=%b want 1", err); end
    wait_wr(200, ok);
    total++; if (!ok || cyc - t_mark != 102 || wr_en !== 3'b010) begin bad++; $display("FAIL row3_write: cycle=%0d wr_en=%b want 102 010", cyc - t_mark, wr_en); end
    total++; if (ram2 !== row_val(300)) begin bad++; $display("FAIL row3_ram2: got %h want %h", ram2, row_val(300)); end
    total++; if (ram1 !== row_val(0) || ram3 !== row_val(200)) begin bad++; $display("FAIL row3_others: ram1 %h ram3 %h want rows 0 and 200", ram1[63:0], ram3[63:0]); end
    tick();
    total++; if (wr_en !== 3'b000 || img_rd_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL pend_wait: wr_en=%b rd_en=%b busy=%b want 000 0 1", wr_en, img_rd_en, busy); end
    tick();
    total++; if (img_rd_en !== 1'b1 || img_rd_addr !== 14'd400) begin bad++; $display("FAIL pend_fetch: rd_en=%b addr=%0d want 1 400", img_rd_en, img_rd_addr); end
    wait_wr(200, ok);
    total++; if (!ok || cyc - t_mark != 205 || wr_en !== 3'b100) begin bad++; $display("FAIL row4_write: cycle=%0d wr_en=%b want 205 100", cyc - t_mark, wr_en); end
    total++; if (ram3 !== row_val(400) || ram2 !== row_val(300) || ram1 !== row_val(0)) begin bad++; $display("FAIL row4_rams: ram3 %h want %h", ram3, row_val(400)); end
    n_wr = 0; n_rd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_en !== 3'b000) n_wr++;
      if (img_rd_en !== 1'b0) n_rd++;
    end
    total++; if (n_wr != 0 || n_rd != 0) begin bad++; $display("FAIL pend_extra: writes=%0d reads=%0d want 0 0", n_wr, n_rd); end
  endtask

  task automatic test_mid_reset();
    int n_wr, n_rd;
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (ram1 !== '0 || ram2 !== '0 || ram3 !== '0) begin bad++; $display("FAIL rst_rams: ram1 %h ram2 %h ram3 %h want 0", ram1[63:0], ram2[63:0], ram3[63:0]); end
    total++; if (busy !== 1'b0 || err !== 1'b0 || wr_en !== 3'b000) begin bad++; $display("FAIL rst_wait: busy=%b err=%b wr_en=%b want 0 0 000", busy, err, wr_en); end
    start = 1'b1; t_mark = cyc; tick(); start = 1'b0;
    repeat (50) tick();
    total++; if (img_rd_en !== 1'b1 || img_rd_addr !== 14'd50) begin bad++; $display("FAIL mid_fetch50: rd_en=%b addr=%0d want 1 50", img_rd_en, img_rd_addr); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (img_rd_en !== 1'b0 || img_rd_addr !== 14'd0 || wr_en !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_rst: rd_en=%b addr=%0d wr_en=%b busy=%b done=%b want all 0", img_rd_en, img_rd_addr, wr_en, busy, done); end
    n_wr = 0; n_rd = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (wr_en !== 3'b000) n_wr++;
      if (img_rd_en !== 1'b0 || busy !== 1'b0) n_rd++;
    end
    total++; if (n_wr != 0 || n_rd != 0 || ram1 !== '0) begin bad++; $display("FAIL mid_quiet: writes=%0d active=%0d ram1 %h want 0 0 0", n_wr, n_rd, ram1[63:0]); end
  endtask

  task automatic test_bad_k();
    int n_act;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL badk_pre: err=%b want 0", err); end
    conv_valid = 1'b1; conv_k = 2'd3; tick(); conv_valid = 1'b0;
    total++; if (err !== 1'b1 || img_rd_en !== 1'b0 || wr_en !== 3'b000) begin bad++; $display("FAIL badk: err=%b rd_en=%b wr_en=%b want 1 0 000", err, img_rd_en, wr_en); end
    n_act = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_en !== 3'b000 || img_rd_en !== 1'b0 || busy !== 1'b1) n_act++;
    end
    total++; if (n_act != 0) begin bad++; $display("FAIL badk_stay: active cycles=%0d want 0", n_act); end
    start = 1'b1; tick(); start = 1'b0;
    total++; if (img_rd_en !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL busy_start: rd_en=%b err=%b want 0 1", img_rd_en, err); end
    conv_valid = 1'b1; conv_k = 2'd0; tick(); conv_valid = 1'b0;
    total++; if (img_rd_en !== 1'b1 || img_rd_addr !== 14'd300) begin bad++; $display("FAIL badk_recover: rd_en=%b addr=%0d want 1 300", img_rd_en, img_rd_addr); end
  endtask

  task automatic test_num_rows3();
    int n_wr, done_at, n_act;
    start_b = 1'b1; t_mark = cyc; tick(); start_b = 1'b0;
    n_wr = 0; done_at = -1;
    for (int i = 0; i < 400 && done_at < 0; i++) begin
      tick();
      if (wr_en_b !== 3'b000) n_wr++;
      if (done_b === 1'b1) done_at = cyc - t_mark;
    end
    total++; if (n_wr != 3 || done_at != 307) begin bad++; $display("FAIL n3_done: writes=%0d done_cycle=%0d want 3 307", n_wr, done_at); end
    total++; if (ram1_b !== row_val(0) || ram3_b !== row_val(200)) begin bad++; $display("FAIL n3_rams: ram3 %h want %h", ram3_b, row_val(200)); end
    conv_valid_b = 1'b1; conv_k_b = 2'd1;
    tick();
    total++; if (done_b !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL n3_after: done=%b busy=%b want 0 0", done_b, busy_b); end
    n_act = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_en_b !== 3'b000 || img_rd_en_b !== 1'b0 || busy_b !== 1'b0) n_act++;
    end
    conv_valid_b = 1'b0;
    total++; if (n_act != 0 || err_b !== 1'b0) begin bad++; $display("FAIL n3_idle_conv: active=%0d err=%b want 0 0", n_act, err_b); end
  endtask

  initial begin
    test_reset();
    test_first_fill("fill");
    test_conv_wait();
    test_pending();
    test_mid_reset();
    test_first_fill("refill");
    test_bad_k();
    test_num_rows3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
